// File: rtl/jt49_noise_pkg.sv
// rtl/jt49_noise_pkg.sv - shared constants and LFSR step function for the noise scheduler
package jt49_noise_pkg;
  localparam int LFSR_W  = 17;
  localparam int TAP_A   = 0;
  localparam int TAP_B   = 2;
  localparam int OUT_BIT = 16;
  localparam logic [LFSR_W-1:0] LFSR_RST = '0;

  // The all-zero state injects a 1 so a freshly reset voice starts on its own.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ (s == LFSR_RST);
    return {fb, s[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/jt49_noise_sched_if.sv
// rtl/jt49_noise_sched_if.sv - register-bank side and mixer side signals of the noise scheduler
interface jt49_noise_sched_if #(
  parameter int NV = 3,
  parameter int PW = 5
);
  logic             cen;
  logic [NV*PW-1:0] period;
  logic [NV-1:0]    noise;
  logic [NV-1:0]    step;
  logic             overrun;

  modport master (output cen, output period, input noise, input step, input overrun);
  modport slave  (input cen, input period, output noise, output step, output overrun);
endinterface

// File: rtl/jt49_rr_arb.sv
// rtl/jt49_rr_arb.sv - round-robin one-hot arbiter, search starts after the last granted index
module jt49_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    idx_nxt = ptr;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
        idx_nxt   = cand;
      end
    end
  end

  // Pointer starts at the last voice so voice 0 wins the first search.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(N - 1);
    end else if (found) begin
      ptr <= idx_nxt;
    end
  end
endmodule

// File: rtl/jt49_noise_sched.sv
// rtl/jt49_noise_sched.sv - per-voice noise prescalers sharing one LFSR step engine
module jt49_noise_sched
  import jt49_noise_pkg::*;
#(
  parameter int NV = 3,
  parameter int PW = 5
) (
  input logic               clk,
  input logic               rst_n,
  jt49_noise_sched_if.slave bus
);
  logic [NV-1:0]     tick;
  logic [NV-1:0]     pend;
  logic [NV-1:0]     gnt;
  logic [NV-1:0]     lost;
  logic [NV-1:0]     step_r;
  logic [NV-1:0]     noise_bits;
  logic              ovr;
  logic [LFSR_W-1:0] st [NV];
  logic [LFSR_W-1:0] sel;
  logic [LFSR_W-1:0] nxt;

  for (genvar v = 0; v < NV; v++) begin : g_voice
    logic [PW-1:0] cnt;
    logic [PW-1:0] per;
    logic [PW:0]   per_m1;

    assign per    = bus.period[v*PW +: PW];
    assign per_m1 = {1'b0, per} - (PW+1)'(1);
    // >= rather than == so a period shrunk below cnt wraps on the next cen.
    assign tick[v] = bus.cen && ((per <= PW'(1)) || ({1'b0, cnt} >= per_m1));
    assign noise_bits[v] = st[v][OUT_BIT];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (bus.cen) begin
        cnt <= tick[v] ? '0 : cnt + PW'(1);
      end
    end
  end

  jt49_rr_arb #(.N(NV)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (pend),
    .gnt   (gnt)
  );

  always_comb begin
    sel = '0;
    for (int v = 0; v < NV; v++) begin
      if (gnt[v]) sel = sel | st[v];
    end
  end

  assign nxt  = lfsr_next(sel);
  assign lost = tick & pend & ~gnt;

  // A tick arriving on the grant clk re-arms pending instead of being dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend   <= '0;
      step_r <= '0;
      ovr    <= 1'b0;
      for (int v = 0; v < NV; v++) st[v] <= LFSR_RST;
    end else begin
      pend   <= tick | (pend & ~gnt);
      step_r <= gnt;
      if (|lost) ovr <= 1'b1;
      for (int v = 0; v < NV; v++) begin
        if (gnt[v]) st[v] <= nxt;
      end
    end
  end

  assign bus.noise   = noise_bits;
  assign bus.step    = step_r;
  assign bus.overrun = ovr;
endmodule

// File: tb/tb_jt49_noise_sched.sv
// tb/tb_jt49_noise_sched.sv - scoreboard bench for the shared noise LFSR scheduler
module tb_jt49_noise_sched;
  localparam int NV = 3;
  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [NV-1:0] exp_q [$];
  logic [16:0]   ref_s [NV];

  jt49_noise_sched_if #(.NV(NV), .PW(PW)) bus ();
  jt49_noise_sched #(.NV(NV), .PW(PW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [16:0] ref_next(input logic [16:0] s);
    return {s[0] ^ s[2] ^ (s == 17'd0), s[16:1]};
  endfunction

  always @(negedge clk) begin : mon
    logic [NV-1:0] e;
    if (bus.step != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected step=%b expected no step", bus.step);
      end else begin
        e = exp_q.pop_front();
        if (bus.step !== e) begin
          errors++;
          $display("FAIL sb_order step=%b expected %b", bus.step, e);
        end
      end
      for (int v = 0; v < NV; v++) begin
        if (bus.step[v]) begin
          ref_s[v] = ref_next(ref_s[v]);
          checks++;
          if (bus.noise[v] !== ref_s[v][16]) begin
            errors++;
            $display("FAIL sb_noise v%0d noise=%b expected %b", v, bus.noise[v], ref_s[v][16]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int v = 0; v < NV; v++) ref_s[v] = 17'd0;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic pulse(output logic [NV-1:0] s0, output logic [NV-1:0] s1,
                       output logic [NV-1:0] s2, output logic [NV-1:0] n0);
    bus.cen = 1'b1;
    @(negedge clk);
    bus.cen = 1'b0;
    @(negedge clk);
    s0 = bus.step;
    n0 = bus.noise;
    @(negedge clk);
    s1 = bus.step;
    @(negedge clk);
    s2 = bus.step;
  endtask

  task automatic drain(input string name);
    repeat (8) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending_expected=%0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.period = '0;
    bus.cen = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks += 3;
    if (bus.step !== '0) begin errors++; $display("FAIL reset_step step=%b expected 000", bus.step); end
    if (bus.noise !== '0) begin errors++; $display("FAIL reset_noise noise=%b expected 000", bus.noise); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun overrun=%b expected 0", bus.overrun); end
    bus.cen = 1'b0;
    for (int v = 0; v < NV; v++) ref_s[v] = 17'd0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NV-1:0] s0, s1, s2, n0;
    do_reset();
    bus.period = {5'd31, 5'd31, 5'd1};
    exp_q.push_back(3'b001);
    pulse(s0, s1, s2, n0);
    checks += 2;
    if (s0 !== 3'b001) begin errors++; $display("FAIL single_step1 step=%b expected 001", s0); end
    if (n0[0] !== 1'b1) begin errors++; $display("FAIL single_noise1 noise0=%b expected 1", n0[0]); end
    exp_q.push_back(3'b001);
    pulse(s0, s1, s2, n0);
    checks += 2;
    if (s0 !== 3'b001) begin errors++; $display("FAIL single_step2 step=%b expected 001", s0); end
    if (n0[0] !== 1'b0) begin errors++; $display("FAIL single_noise2 noise0=%b expected 0", n0[0]); end
    drain("single");
  endtask

  task automatic test_three_spaced();
    logic [NV-1:0] s0, s1, s2, n0;
    do_reset();
    bus.period = {5'd1, 5'd1, 5'd1};
    for (int i = 0; i < 1000; i++) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
      pulse(s0, s1, s2, n0);
      checks++;
      if (s0 !== 3'b001 || s1 !== 3'b010 || s2 !== 3'b100) begin
        errors++;
        $display("FAIL spaced_seq cen%0d steps=%b,%b,%b expected 001,010,100", i, s0, s1, s2);
      end
    end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL spaced_overrun overrun=%b expected 0", bus.overrun); end
    drain("spaced");
  endtask

  task automatic test_cen_high();
    logic [NV-1:0] e;
    do_reset();
    bus.period = {5'd1, 5'd1, 5'd1};
    for (int i = 0; i < 32; i++) exp_q.push_back(NV'(1 << (i % 3)));
    bus.cen = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL cenhigh_overrun overrun=%b expected 1", bus.overrun); end
      end
      if (i == 28) bus.cen = 1'b0;
      e = NV'(1 << (i % 3));
      checks++;
      if (bus.step !== e) begin errors++; $display("FAIL cenhigh_rotation clk%0d step=%b expected %b", i, bus.step, e); end
    end
    drain("cenhigh");
  endtask

  task automatic test_period_change();
    logic [NV-1:0] s0, s1, s2, n0, e;
    do_reset();
    bus.period = {5'd31, 5'd10, 5'd31};
    for (int c = 1; c <= 16; c++) begin
      if (c == 8) bus.period[PW +: PW] = 5'd4;
      e = (c == 8 || c == 12 || c == 16) ? 3'b010 : 3'b000;
      if (e != '0) exp_q.push_back(e);
      pulse(s0, s1, s2, n0);
      checks++;
      if (s0 !== e) begin errors++; $display("FAIL period_change cen%0d step=%b expected %b", c, s0, e); end
    end
    drain("period");
  endtask

  task automatic test_same_clk();
    do_reset();
    bus.period = {5'd1, 5'd31, 5'd31};
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    bus.cen = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.step !== 3'b100) begin errors++; $display("FAIL sameclk_first step=%b expected 100", bus.step); end
    bus.cen = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.step !== 3'b100) begin errors++; $display("FAIL sameclk_second step=%b expected 100", bus.step); end
    @(negedge clk);
    checks += 2;
    if (bus.step !== 3'b000) begin errors++; $display("FAIL sameclk_idle step=%b expected 000", bus.step); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL sameclk_overrun overrun=%b expected 0", bus.overrun); end
    drain("sameclk");
  endtask

  task automatic test_reset_mid();
    logic [NV-1:0] s0, s1, s2, n0;
    do_reset();
    bus.period = {5'd1, 5'd1, 5'd1};
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    bus.cen = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL midrst_pre_overrun overrun=%b expected 1", bus.overrun); end
    bus.cen = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.step !== '0) begin errors++; $display("FAIL midrst_step step=%b expected 000", bus.step); end
    if (bus.noise !== '0) begin errors++; $display("FAIL midrst_noise noise=%b expected 000", bus.noise); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun overrun=%b expected 0", bus.overrun); end
    for (int v = 0; v < NV; v++) ref_s[v] = 17'd0;
    rst_n = 1'b1;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    pulse(s0, s1, s2, n0);
    checks++;
    if (s0 !== 3'b001) begin errors++; $display("FAIL midrst_first_grant step=%b expected 001", s0); end
    drain("midrst");
  endtask

  initial begin
    bus.cen = 1'b0;
    bus.period = '0;
    test_reset();
    test_single();
    test_three_spaced();
    test_cen_high();
    test_period_change();
    test_same_clk();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
